// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit with HI/LO registers.
//
// One MULTU/DIVU/MULT/DIV operation is launched per start pulse. The datapath
// runs a shift-add multiply or a restoring divide for WIDTH cycles and then
// spends one cycle publishing the result into HI/LO. MTHI/MTLO writes are
// accepted while idle.
//
// Build option: define MDU_SIGNED_EN to enable signed MULT/DIV (op_i[1]).
// Without it every operation is unsigned and no sign-correction logic exists.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i, op_i         launch strobe and opcode (00 MULTU, 01 DIVU, 10 MULT, 11 DIV)
//   a_i, b_i              multiplicand/dividend, multiplier/divisor
//   flush_i               abort an in-flight operation
//   hi_we_i, lo_we_i      MTHI / MTLO write enables, data on wdata_i
//   busy_o                operation in flight (stall request)
//   done_o, dbz_o         result-publish pulse, divide-by-zero flag
//   hi_o, lo_o            HI / LO registers
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; MTHI/MTLO writes accepted here
// RUN   | one multiply/divide iteration per cycle, counter counts down
// FIN   | sign correction, result written to HI/LO on the exit edge

module mul_div_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // opa: multiplier (shifts right) or dividend (shifts left)
  // opb: multiplicand or divisor, constant during RUN
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
`ifdef MDU_SIGNED_EN
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
`else
  logic               unused_op_sign;
  assign unused_op_sign = op_i[1];
`endif

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_borrow;
  logic [2*WIDTH-1:0] res_prod;
  logic [WIDTH-1:0]   res_quot;
  logic [WIDTH-1:0]   res_rem;

  always_comb begin
`ifdef MDU_SIGNED_EN
    sign_a = op_i[1] & a_i[WIDTH-1];
    sign_b = op_i[1] & b_i[WIDTH-1];
    mag_a  = sign_a ? -a_i : a_i;
    mag_b  = sign_b ? -b_i : b_i;
`else
    sign_a = 1'b0;
    sign_b = 1'b0;
    mag_a  = a_i;
    mag_b  = b_i;
`endif

    mul_addend = opa_q[0] ? opb_q : {WIDTH{1'b0}};
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

    // Remainder fits in WIDTH bits, so bit WIDTH of the difference is the borrow.
    div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
    div_diff   = div_rem_sh - {1'b0, opb_q};
    div_borrow = div_diff[WIDTH];

    res_prod = acc_q;
    res_quot = acc_q[WIDTH-1:0];
    res_rem  = acc_q[2*WIDTH-1:WIDTH];
`ifdef MDU_SIGNED_EN
    if (neg_q) begin
      res_prod = -acc_q;
      res_quot = -acc_q[WIDTH-1:0];
    end
    if (neg_rem_q) begin
      res_rem = -acc_q[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    dbz_d   = dbz_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    araw_d  = araw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_SIGNED_EN
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(WIDTH);
          div_d   = op_i[0];
          dbz_d   = op_i[0] & (b_i == '0);
          acc_d   = '0;
          araw_d  = a_i;
          opa_d   = op_i[0] ? mag_a : mag_b;
          opb_d   = op_i[0] ? mag_b : mag_a;
`ifdef MDU_SIGNED_EN
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a & op_i[0];
`endif
        end else begin
          if (hi_we_i) hi_d = wdata_i;
          if (lo_we_i) lo_d = wdata_i;
        end
      end

      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIN;
          if (div_q) begin
            acc_d[2*WIDTH-1:WIDTH] = div_borrow ? div_rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc_d[WIDTH-1:0]       = {acc_q[WIDTH-2:0], ~div_borrow};
            opa_d                  = opa_q << 1;
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            opa_d = opa_q >> 1;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        // done_o is decoded from state, so a flush landing in FIN can only
        // suppress the HI/LO write, not the pulse already on the wire.
        if (!flush_i) begin
          if (!div_q) begin
            {hi_d, lo_d} = res_prod;
          end else if (dbz_q) begin
            hi_d = araw_q;
            lo_d = '1;
          end else begin
            hi_d = res_rem;
            lo_d = res_quot;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      dbz_q     <= 1'b0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      araw_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MDU_SIGNED_EN
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      dbz_q     <= dbz_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      araw_q    <= araw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MDU_SIGNED_EN
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_FIN);
  assign dbz_o  = (state_q == S_FIN) & dbz_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         flush_i;
  logic         hi_we_i, lo_we_i;
  logic [W-1:0] wdata_i;
  logic         busy_o, done_o, dbz_o;
  logic [W-1:0] hi_o, lo_o;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .hi_we_i(hi_we_i),
    .lo_we_i(lo_we_i), .wdata_i(wdata_i), .busy_o(busy_o),
    .done_o(done_o), .dbz_o(dbz_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     t0_cyc = 0;
  logic [W-1:0] cur_hi = '0, cur_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  // Reference model: plain integer arithmetic at 64 bits.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    logic   sgn;
    logic [63:0] p;
    longint sq, sr;
`ifdef MDU_SIGNED_EN
    sgn = op[1];
`else
    sgn = 1'b0;
`endif
    e.dbz = 1'b0;
    if (!op[0]) begin
      if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else     p = 64'(a) * 64'(b);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.dbz = 1'b1;
      e.hi  = a;
      e.lo  = '1;
    end else if (sgn) begin
      sq = longint'($signed(a)) / longint'($signed(b));
      sr = longint'($signed(a)) % longint'($signed(b));
      e.lo = sq[31:0];
      e.hi = sr[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    sb.push_back(model(op, a, b));
    tick();
    t0_cyc  = cyc;
    start_i = 1'b0;
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
  endtask

  task automatic finish_op(input string tag);
    exp_t e;
    bit   all_busy;
    all_busy = 1'b1;
    while (!done_o && (cyc - t0_cyc) < 100) begin
      all_busy &= busy_o;
      tick();
    end
    chk({tag, "_latency"}, 64'(cyc - t0_cyc), 64'(W));
    chk({tag, "_busy_run"}, {63'd0, all_busy & busy_o}, 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_dbz"}, {63'd0, dbz_o}, {63'd0, e.dbz});
    tick();
    chk({tag, "_idle_after"}, {62'd0, busy_o, done_o}, 64'd0);
    chk({tag, "_hi"}, 64'(hi_o), 64'(e.hi));
    chk({tag, "_lo"}, 64'(lo_o), 64'(e.lo));
    cur_hi = e.hi;
    cur_lo = e.lo;
  endtask

  initial begin
    bit seen_done;
    rst_i = 1'b0; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    flush_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0;
    #1 rst_i = 1'b1;
    #1;
    chk("reset_outputs", {busy_o, done_o, dbz_o, hi_o[30:0], lo_o}, 64'd0);
    chk("reset_hi_msb", {63'd0, hi_o[31]}, 64'd0);
    repeat (2) tick();
    @(negedge clk_i) rst_i = 1'b0;
    tick();

    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy_t0", {63'd0, busy_o}, 64'd1);
    finish_op("multu_max");
    chk("multu_max_hi_const", 64'(cur_hi), 64'h0000_0000_FFFF_FFFE);

    start_op(2'b01, 32'd100, 32'd7);
    finish_op("divu_100_7");
    start_op(2'b11, -32'sd100, 32'd7);
    finish_op("div_m100_7");
    start_op(2'b10, -32'sd3, 32'd5);
    finish_op("mult_m3_5");
    start_op(2'b01, 32'h1234, 32'd0);
    finish_op("divu_dbz");
    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_min_m1");
    start_op(2'b11, 32'd7, -32'sd2);
    finish_op("div_7_m2");
    start_op(2'b10, 32'h8000_0000, 32'h8000_0000);
    finish_op("mult_min_min");

    // MTLO in idle
    lo_we_i = 1'b1; wdata_i = 32'hA5A5_A5A5;
    tick();
    lo_we_i = 1'b0;
    chk("mtlo_idle", 64'(lo_o), 64'hA5A5_A5A5);
    cur_lo = 32'hA5A5_A5A5;

    // MTHI coincident with start is dropped
    hi_we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    start_op(2'b00, 32'd3, 32'd5);
    chk("mthi_with_start", 64'(hi_o), 64'(cur_hi));
    // MTHI while busy is dropped
    hi_we_i = 1'b1; wdata_i = 32'h1111_2222;
    tick();
    hi_we_i = 1'b0;
    tick();
    chk("mthi_busy", 64'(hi_o), 64'(cur_hi));
    finish_op("multu_3_5");

    // flush mid-run
    start_op(2'b10, 32'd1234, -32'sd77);
    seen_done = 1'b0;
    repeat (10) begin
      tick();
      seen_done |= done_o;
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    void'(sb.pop_back());
    chk("flush_busy_low", {63'd0, busy_o}, 64'd0);
    repeat (3) begin
      seen_done |= done_o;
      tick();
    end
    chk("flush_no_done", {63'd0, seen_done}, 64'd0);
    chk("flush_hi_kept", 64'(hi_o), 64'(cur_hi));
    chk("flush_lo_kept", 64'(lo_o), 64'(cur_lo));
    start_op(2'b01, 32'hFFFF_FFF0, 32'd3);
    finish_op("after_flush");

    // asynchronous reset mid-run
    start_op(2'b00, 32'd99, 32'd99);
    repeat (5) tick();
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_ctrl", {62'd0, busy_o, done_o}, 64'd0);
    chk("async_rst_hilo", {hi_o, lo_o}, 64'd0);
    sb.delete();
    cur_hi = '0; cur_lo = '0;
    @(negedge clk_i) rst_i = 1'b0;
    tick();
    start_op(2'b11, 32'd1000, 32'd33);
    finish_op("after_reset");

    for (int i = 0; i < 6; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : $urandom;
      start_op(rop, ra, rb);
      finish_op($sformatf("rand%0d_op%0d", i, rop));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
